// File: rtl/ram_dma_pkg.sv
// Purpose: shared FSM encoding and constants for the ram_dma_copy word-copy engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a. VRD/VWAIT states exist only when RAM_DMA_VERIFY_EN is defined.
package ram_dma_pkg;

  // FSM encoding; the verify states are only present in verify builds.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StWait  = 3'd2,
    StWr    = 3'd3,
`ifdef RAM_DMA_VERIFY_EN
    StVrd   = 3'd4,
    StVwait = 3'd5,
`endif
    StDone  = 3'd6
  } ram_dma_state_e;

  // Address step per copied word.
  localparam logic [31:0] WordBytes = 32'd4;

  // Byte enables for a full-word write.
  localparam logic [3:0]  BeFull    = 4'hF;

endpackage

// File: rtl/ram_dma_copy.sv
// Purpose: copies len_i 32-bit words from src_addr_i to dst_addr_i over a single-port RAM port.
// Latency: 3 cycles per word (5 with RAM_DMA_VERIFY_EN read-back), done_o one cycle after the last word.
// Backpressure: WAIT/VWAIT stall indefinitely until rvalid_i; start_i is ignored while busy_o=1.
module ram_dma_copy
  import ram_dma_pkg::*;
#(
  parameter int unsigned LenW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            req_o,
  output logic            we_o,
  output logic [3:0]      be_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
  input  logic            rvalid_i,
  input  logic [31:0]     rdata_i
);

  ram_dma_state_e  state_q;
  logic [31:0]     src_q;
  logic [31:0]     dst_q;
  logic [31:0]     data_q;
  logic [LenW-1:0] cnt_q;
  logic            err_q;

  // Copy sequencer: RD -> WAIT -> WR (-> VRD -> VWAIT) per word, DONE after the last word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            src_q <= src_addr_i;
            dst_q <= dst_addr_i;
            cnt_q <= len_i;
            err_q <= 1'b0;
            if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else if (len_i == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: state_q <= StWait;
        StWait: begin
          if (rvalid_i) begin
            data_q  <= rdata_i;
            state_q <= StWr;
          end
        end
`ifdef RAM_DMA_VERIFY_EN
        StWr:  state_q <= StVrd;
        StVrd: state_q <= StVwait;
        StVwait: begin
          if (rvalid_i) begin
            if (rdata_i != data_q) begin
              // Read-back mismatch aborts without advancing the pointers.
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              src_q   <= src_q + WordBytes;
              dst_q   <= dst_q + WordBytes;
              cnt_q   <= cnt_q - LenW'(1);
              state_q <= (cnt_q == LenW'(1)) ? StDone : StRd;
            end
          end
        end
`else
        StWr: begin
          src_q   <= src_q + WordBytes;
          dst_q   <= dst_q + WordBytes;
          cnt_q   <= cnt_q - LenW'(1);
          state_q <= (cnt_q == LenW'(1)) ? StDone : StRd;
        end
`endif
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM port and status decoded from state only, so reset drops req_o asynchronously.
  always_comb begin
    busy_o  = (state_q != StIdle);
    done_o  = (state_q == StDone);
    err_o   = err_q;
    req_o   = 1'b0;
    we_o    = 1'b0;
    be_o    = 4'h0;
    addr_o  = 32'h0;
    wdata_o = 32'h0;
    case (state_q)
      StRd: begin
        req_o  = 1'b1;
        addr_o = src_q;
      end
      StWr: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        be_o    = BeFull;
        addr_o  = dst_q;
        wdata_o = data_q;
      end
`ifdef RAM_DMA_VERIFY_EN
      StVrd: begin
        req_o  = 1'b1;
        addr_o = dst_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Purpose: self-checking bench for ram_dma_copy against a 128-word 1-cycle RAM responder model.
// Latency: checks done_o cycle offsets (3 cycles/word, 5 with RAM_DMA_VERIFY_EN).
// Backpressure: responder always answers reads one cycle after the request.
module tb_ram_dma_copy;

`ifdef RAM_DMA_VERIFY_EN
  localparam int Pw = 5;
`else
  localparam int Pw = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_in = '0;
  logic        busy_o, done_o, err_o, req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        rv_m = 1'b0;
  logic [31:0] rd_m = '0;

  // Responder RAM with a backdoor preload port and an optional read-back corruption.
  logic [31:0] mem [128];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;
  logic        corrupt_on = 1'b0;
  logic [31:0] corrupt_addr = '0;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  ram_dma_copy #(.LenW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len_in),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rv_m), .rdata_i(rd_m)
  );

  always @(posedge clk) begin
    rv_m <= 1'b0;
    if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (req_o) begin
      if (we_o) begin
        mem[addr_o[8:2]] <= wdata_o;
      end else begin
        rd_m <= (corrupt_on && addr_o == corrupt_addr) ? 32'hDEADBEEF : mem[addr_o[8:2]];
        rv_m <= 1'b1;
      end
    end
  end

  task automatic poke(input logic [6:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Runs one transfer, scoreboarding every write; rogue_at>0 pulses a bogus start in that cycle.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                          input int exp_words, input int rogue_at, output int n, output int reqs);
    logic [31:0] a;
    logic [63:0] e;
    for (int i = 0; i < exp_words; i++) begin
      a = src + 32'(4 * i);
      exp_q.push_back({dst + 32'(4 * i), mem[a[8:2]]});
    end
    @(negedge clk);
    src_addr = src; dst_addr = dst; len_in = len; start = 1'b1;
    n = 0; reqs = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == rogue_at) begin
        start = 1'b1; src_addr = 32'h10; dst_addr = 32'h20; len_in = 16'd7;
      end else begin
        start = 1'b0; src_addr = src; dst_addr = dst; len_in = len;
      end
      if (req_o) reqs++;
      if (req_o && we_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, none expected", addr_o, wdata_o);
        end else begin
          e = exp_q.pop_front();
          if ({be_o, addr_o, wdata_o} !== {4'hF, e}) begin
            errors++;
            $display("FAIL write_data: got be=%h addr=%h data=%h, want be=f addr=%h data=%h",
                     be_o, addr_o, wdata_o, e[63:32], e[31:0]);
          end
        end
      end
      if (done_o) break;
    end
    start = 1'b0;
    checks++;
    if (!done_o) begin
      errors++;
      $display("FAIL done_timeout: no done_o after %0d cycles", n);
    end
  endtask

  task automatic check_tail(input string name, input int n, input int want_n,
                            input logic want_err);
    checks++;
    if (n !== want_n) begin
      errors++;
      $display("FAIL %s_latency: done at E+%0d, want E+%0d", name, n, want_n);
    end
    checks++;
    if (err_o !== want_err) begin
      errors++;
      $display("FAIL %s_err: got %b want %b", name, err_o, want_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d expected writes never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, req_o, we_o, be_o, addr_o, wdata_o} !== 73'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b req=%b we=%b be=%h addr=%h wdata=%h, want all 0",
               busy_o, done_o, err_o, req_o, we_o, be_o, addr_o, wdata_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, req_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b req=%b, want 000", busy_o, done_o, req_o);
    end
  endtask

  task automatic test_copy4;
    int n, reqs;
    poke(7'd0, 32'h11111111); poke(7'd1, 32'h22222222);
    poke(7'd2, 32'h33333333); poke(7'd3, 32'h44444444);
    run_xfer(32'h0, 32'h100, 16'd4, 4, 0, n, reqs);
    check_tail("copy4", n, 3 * 0 + Pw * 4 + 1, 1'b0);
    checks++;
    if (mem[66] !== 32'h33333333 || mem[67] !== 32'h44444444) begin
      errors++;
      $display("FAIL copy4_dest: got %h %h want 33333333 44444444", mem[66], mem[67]);
    end
  endtask

  task automatic test_len0;
    int n, reqs;
    run_xfer(32'h0, 32'h100, 16'd0, 0, 0, n, reqs);
    check_tail("len0", n, 1, 1'b0);
    checks++;
    if (reqs !== 0) begin
      errors++;
      $display("FAIL len0_req: got %0d requests want 0", reqs);
    end
  endtask

  task automatic test_misaligned;
    int n, reqs;
    run_xfer(32'h2, 32'h100, 16'd3, 0, 0, n, reqs);
    check_tail("misalign", n, 1, 1'b1);
    checks++;
    if (reqs !== 0) begin
      errors++;
      $display("FAIL misalign_req: got %0d requests want 0", reqs);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL misalign_err_hold: got err=%b busy=%b want err=1 busy=0", err_o, busy_o);
    end
  endtask

  task automatic test_start_while_busy;
    int n, reqs;
    poke(7'd8, 32'hCAFE0001); poke(7'd9, 32'hCAFE0002); poke(7'd10, 32'hCAFE0003);
    run_xfer(32'h20, 32'h140, 16'd3, 3, 4, n, reqs);
    check_tail("busy_start", n, Pw * 3 + 1, 1'b0);
  endtask

  task automatic test_addr_wrap;
    int n, reqs;
    poke(7'd127, 32'h7F7F7F7F);
    run_xfer(32'hFFFF_FFFC, 32'h180, 16'd2, 2, 0, n, reqs);
    check_tail("wrap", n, Pw * 2 + 1, 1'b0);
  endtask

  task automatic test_reset_mid_write;
    int n, wr, reqs;
    int wr2;
    wr2 = Pw + 3;
    poke(7'd16, 32'hA0000001); poke(7'd17, 32'hA0000002);
    poke(7'd18, 32'hA0000003); poke(7'd19, 32'hA0000004);
    poke(7'd112, 32'h0); poke(7'd113, 32'h0);
    @(negedge clk);
    src_addr = 32'h40; dst_addr = 32'h1C0; len_in = 16'd4; start = 1'b1;
    n = 0; wr = 0;
    while (n < wr2) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n < wr2 && req_o && we_o) wr++;
    end
    checks++;
    if ({req_o, we_o, addr_o} !== {2'b11, 32'h1C4}) begin
      errors++;
      $display("FAIL rst_pre_wr2: got req=%b we=%b addr=%h want 1 1 000001c4", req_o, we_o, addr_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_drop: got req=%b busy=%b want 0 0", req_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || wr !== 1) begin
      errors++;
      $display("FAIL rst_after: got busy=%b writes=%0d want busy=0 writes=1", busy_o, wr);
    end
    checks++;
    if (mem[112] !== 32'hA0000001 || mem[113] !== 32'h0) begin
      errors++;
      $display("FAIL rst_mem: got %h %h want a0000001 00000000", mem[112], mem[113]);
    end
    run_xfer(32'h40, 32'h1C0, 16'd4, 4, 0, n, reqs);
    check_tail("rst_recopy", n, Pw * 4 + 1, 1'b0);
  endtask

`ifdef RAM_DMA_VERIFY_EN
  task automatic test_verify_mismatch;
    int n, reqs;
    poke(7'd24, 32'hB0000001); poke(7'd25, 32'hB0000002);
    corrupt_on = 1'b1; corrupt_addr = 32'h1A0;
    run_xfer(32'h60, 32'h1A0, 16'd2, 1, 0, n, reqs);
    corrupt_on = 1'b0;
    check_tail("verify_mismatch", n, 6, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_copy4();
    test_len0();
    test_misaligned();
    test_start_while_busy();
    test_addr_wrap();
    test_reset_mid_write();
`ifdef RAM_DMA_VERIFY_EN
    test_verify_mismatch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
